// File: rtl/muldiv4_pkg.sv
// Shared types and constants for the 4-bit sequential multiply/divide controller.
package muldiv4_pkg;

    // Operand width used when the instantiating level does not override it.
    localparam int DEFAULT_WIDTH = 4;

    // Operation select encodings carried on the op input.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Controller states. IDLE and DONE are the only states that accept a request.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bits needed for an iteration counter that runs 0 .. w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/muldiv4_step.sv
// One combinational iteration of the unsigned magnitude datapath.
//   multiply: acc = {partial product, remaining multiplier bits}; conditional
//             add of the multiplicand into the upper half, then shift right.
//   divide:   acc = {partial remainder, remaining dividend / quotient bits};
//             shift left, trial-subtract the divisor, restore on borrow.
module muldiv4_step
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic               diff_msb_unused;

    // Shift-add multiply step; the carry out of the add becomes the new msb.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};
    end

    // Restoring divide step; the shifted remainder needs one extra bit because
    // it may momentarily reach twice the divisor before the subtract.
    always_comb begin
        div_shift       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_fits        = (div_shift >= {1'b0, operand});
        div_diff        = div_shift - {1'b0, operand};
        diff_msb_unused = div_diff[WIDTH];
        div_rem         = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next        = {div_rem, acc[WIDTH-2:0], div_fits};
    end

    // Select the step matching the operation in flight.
    always_comb begin
        acc_next = (op == OP_DIV) ? div_next : mul_next;
    end

endmodule

// File: rtl/muldiv4_seq_ctrl.sv
// Sequencing controller for the iterative 4-bit multiply / restoring divide.
// Accepts a request in IDLE or DONE, converts signed operands to magnitudes,
// iterates WIDTH steps, applies the sign fix-up and pulses done for one cycle.
// Divide by zero short-circuits from LOAD straight to DONE.
module muldiv4_seq_ctrl
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               op,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               dbz,
    output logic               ovf
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 op_reg;
    logic                 sgn_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     operand_reg;
    logic                 res_neg_reg;
    logic                 rem_neg_reg;
    logic                 ovf_pend_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic                 dbz_reg;
    logic                 ovf_reg;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 div_zero;
    logic                 ovf_det;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [2*WIDTH-1:0]   fixed_result;

    // Operand signs and magnitudes from the captured request. The most negative
    // value negates to itself, which is still the correct unsigned magnitude.
    always_comb begin
        a_neg    = sgn_reg & a_reg[WIDTH-1];
        b_neg    = sgn_reg & b_reg[WIDTH-1];
        mag_a    = a_neg ? -a_reg : a_reg;
        mag_b    = b_neg ? -b_reg : b_reg;
        div_zero = (op_reg == OP_DIV) && (b_reg == '0);
        ovf_det  = sgn_reg && (op_reg == OP_DIV) &&
                   (a_reg == MOST_NEG) && (b_reg == '1);
    end

    // Single shared iteration datapath.
    muldiv4_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .op       (op_reg),
        .acc      (acc_reg),
        .operand  (operand_reg),
        .acc_next (acc_next)
    );

    // Sign fix-up of the magnitude result: quotient/product follow the
    // combined sign, remainder follows the dividend.
    always_comb begin
        quot_fix     = res_neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix      = rem_neg_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                   : acc_reg[2*WIDTH-1:WIDTH];
        prod_fix     = res_neg_reg ? -acc_reg : acc_reg;
        fixed_result = (op_reg == OP_DIV) ? {rem_fix, quot_fix} : prod_fix;
    end

    // Controller FSM with registered handshake and result outputs; ena low
    // freezes every register including the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            op_reg       <= 1'b0;
            sgn_reg      <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            operand_reg  <= '0;
            res_neg_reg  <= 1'b0;
            rem_neg_reg  <= 1'b0;
            ovf_pend_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (ena) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        sgn_reg   <= sgn;
                        a_reg     <= a;
                        b_reg     <= b;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    res_neg_reg  <= a_neg ^ b_neg;
                    rem_neg_reg  <= a_neg;
                    ovf_pend_reg <= ovf_det;
                    if (div_zero) begin
                        // Quotient all ones, remainder is the raw dividend.
                        result_reg <= {a_reg, {WIDTH{1'b1}}};
                        dbz_reg    <= 1'b1;
                        ovf_reg    <= 1'b0;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        cnt_reg <= '0;
                        if (op_reg == OP_DIV) begin
                            acc_reg     <= {{WIDTH{1'b0}}, mag_a};
                            operand_reg <= mag_b;
                        end else begin
                            acc_reg     <= {{WIDTH{1'b0}}, mag_b};
                            operand_reg <= mag_a;
                        end
                        state_reg <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    result_reg <= fixed_result;
                    dbz_reg    <= 1'b0;
                    ovf_reg    <= ovf_pend_reg;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= ST_DONE;
                end

                ST_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg    <= op;
                        sgn_reg   <= sgn;
                        a_reg     <= a;
                        b_reg     <= b;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign dbz    = dbz_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_muldiv4_seq_ctrl.sv
// Self-checking bench for muldiv4_seq_ctrl: directed cases, handshake and
// control scenarios, and randomized operations against an arithmetic model.
module tb_muldiv4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       op;
    logic       sgn;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       dbz;
    logic       ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muldiv4_seq_ctrl #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .op     (op),
        .sgn    (sgn),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dbz    (dbz),
        .ovf    (ovf)
    );

    // Reference: {dbz, ovf, result} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic o, input logic s,
                                         input logic [3:0] x, input logic [3:0] y);
        int sx, sy, p, q, r;
        logic [9:0] m;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        if (!o) begin
            p = sx * sy;
            m = {2'b00, p[7:0]};
        end else if (y == 4'd0) begin
            m = {2'b10, x, 4'hF};
        end else if (s && sx == -8 && sy == -1) begin
            m = {2'b01, 8'h08};
        end else begin
            q = sx / sy;
            r = sx % sy;
            m = {2'b00, r[3:0], q[3:0]};
        end
        return m;
    endfunction

    // Issue one request at the current negedge; returns cycles until done is
    // seen (1 = the cycle after acceptance) and whether busy stayed high.
    task automatic run_op(input logic o, input logic s, input logic [3:0] x,
                          input logic [3:0] y, output int lat, output bit busy_ok);
        op = o; sgn = s; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); op = 1'($urandom); sgn = 1'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; op = 0; sgn = 0; a = 0; b = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, dbz, ovf, result} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b ovf=%b result=%h, want all 0",
                     busy, done, dbz, ovf, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [9:0] vec [8] = '{10'b0_0_1111_1111, 10'b0_1_1101_0101, 10'b0_1_1000_1000,
                                10'b1_0_1101_0100, 10'b1_1_1001_0010, 10'b1_1_1000_1111,
                                10'b1_0_1111_0001, 10'b0_0_0000_0111};
        logic [7:0] want [8] = '{8'hE1, 8'hF1, 8'h40, 8'h13, 8'hFD, 8'h08, 8'h0F, 8'h00};
        logic want_ovf [8]   = '{0, 0, 0, 0, 0, 1, 0, 0};
        int lat; bit bok;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run_op(vec[i][9], vec[i][8], vec[i][7:4], vec[i][3:0], lat, bok);
            tests_run++;
            if (result !== want[i] || dbz !== 1'b0 || ovf !== want_ovf[i] ||
                lat != 7 || !bok || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_%0d: got result=%h dbz=%b ovf=%b lat=%0d busy_ok=%b busy=%b, want result=%h dbz=0 ovf=%b lat=7 busy_ok=1 busy=0",
                         i, result, dbz, ovf, lat, bok, busy, want[i], want_ovf[i]);
            end
        end
    endtask

    task automatic test_dbz();
        int lat; bit bok;
        @(negedge clk);
        run_op(1'b1, 1'b0, 4'h9, 4'h0, lat, bok);
        tests_run++;
        if (result !== 8'h9F || dbz !== 1'b1 || ovf !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL dbz_unsigned: got result=%h dbz=%b ovf=%b lat=%0d, want 9f 1 0 2",
                     result, dbz, ovf, lat);
        end
        run_op(1'b1, 1'b1, 4'h8, 4'h0, lat, bok);
        tests_run++;
        if (result !== 8'h8F || dbz !== 1'b1 || ovf !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL dbz_signed: got result=%h dbz=%b ovf=%b lat=%0d, want 8f 1 0 2",
                     result, dbz, ovf, lat);
        end
        run_op(1'b0, 1'b0, 4'h3, 4'h3, lat, bok);
        tests_run++;
        if (result !== 8'h09 || dbz !== 1'b0 || lat != 7) begin
            tests_failed++;
            $display("FAIL dbz_clear: got result=%h dbz=%b lat=%0d, want 09 0 7", result, dbz, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        @(negedge clk);
        run_op(1'b1, 1'b0, 4'hD, 4'h4, lat, bok);
        tests_run++;
        if (result !== 8'h13 || lat != 7) begin
            tests_failed++;
            $display("FAIL b2b_first: got result=%h lat=%0d, want 13 7", result, lat);
        end
        // Still in the DONE cycle: the next request must be taken immediately.
        run_op(1'b0, 1'b0, 4'h2, 4'h3, lat, bok);
        tests_run++;
        if (result !== 8'h06 || lat != 7 || !bok) begin
            tests_failed++;
            $display("FAIL b2b_second: got result=%h lat=%0d busy_ok=%b, want 06 7 1",
                     result, lat, bok);
        end
    endtask

    task automatic test_ena_stall();
        int lat;
        logic [7:0] held;
        bit frozen_ok = 1'b1;
        @(negedge clk);
        op = 1'b0; sgn = 1'b0; a = 4'h7; b = 4'h6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        @(negedge clk); lat++;
        @(negedge clk); lat++;
        held = result;
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk); lat++;
            if (done !== 1'b0 || busy !== 1'b1 || result !== held) frozen_ok = 1'b0;
        end
        ena = 1'b1;
        while (!done && lat < 40) begin
            @(negedge clk); lat++;
        end
        tests_run++;
        if (lat != 10 || result !== 8'h2A || !frozen_ok) begin
            tests_failed++;
            $display("FAIL ena_stall: got lat=%0d result=%h frozen_ok=%b, want 10 2a 1",
                     lat, result, frozen_ok);
        end
    endtask

    task automatic test_start_busy();
        int lat;
        bit idle_ok = 1'b1;
        @(negedge clk);
        op = 1'b0; sgn = 1'b0; a = 4'h5; b = 4'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        @(negedge clk); lat++;
        op = 1'b1; a = 4'hF; b = 4'h0; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk); lat++;
        end
        tests_run++;
        if (lat != 7 || result !== 8'h0F || dbz !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_busy: got lat=%0d result=%h dbz=%b, want 7 0f 0", lat, result, dbz);
        end
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
        end
        tests_run++;
        if (!idle_ok) begin
            tests_failed++;
            $display("FAIL start_busy_idle: got extra activity after done, want idle");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        op = 1'b0; sgn = 1'b0; a = 4'hF; b = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || dbz !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h dbz=%b ovf=%b, want 0 0 00 0 0",
                     busy, done, result, dbz, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_no_resume: got busy=%b done=%b result=%h, want 0 0 00",
                     busy, done, result);
        end
    endtask

    task automatic test_random();
        int lat; bit bok;
        logic o, s;
        logic [3:0] x, y;
        logic [9:0] m;
        int want_lat;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            o = 1'($urandom); s = 1'($urandom);
            x = 4'($urandom); y = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            if (i == 10) begin o = 1'b1; s = 1'b1; x = 4'h8; y = 4'hF; end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            m = model(o, s, x, y);
            want_lat = m[9] ? 2 : 7;
            run_op(o, s, x, y, lat, bok);
            tests_run++;
            if (result !== m[7:0] || dbz !== m[9] || ovf !== m[8] || lat != want_lat) begin
                tests_failed++;
                $display("FAIL random_%0d op=%b sgn=%b a=%h b=%h: got result=%h dbz=%b ovf=%b lat=%0d, want %h %b %b %0d",
                         i, o, s, x, y, result, dbz, ovf, lat, m[7:0], m[9], m[8], want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_dbz();
        test_back_to_back();
        test_ena_stall();
        test_start_busy();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
